hazard_ctrl: RTL

Parametrised hazard detection and stall controller for the 5-stage MIPS pipeline, sitting beside the IF/ID and ID/EX registers. Generalises load-use detection with configurable register-address width and a multi-cycle load-use window. Adds a data-memory wait freeze, zero-register and unused-source filtering, branch-taken IF/ID flush, and a saturating stall-cycle counter. Optional branch-operand hazard detection is compiled in by macro.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_match.sv | 21 ++
 rtl/hazard_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// No logic; FSM state encoding, idle control values, default load-use depth.
// Imported by hazard_ctrl.
package hazard_pkg;

  // Load-use controller states: normal issue, or owing further bubbles.
  typedef enum logic {
    RUN       = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  // Bubbles inserted per load-use hazard when not overridden.
  localparam int DEFAULT_LOAD_USE_CYCLES = 1;

  // Control outputs when nothing is stalling, freezing or flushing.
  localparam logic IDLE_PC_WRITE    = 1'b1;
  localparam logic IDLE_IFID_WRITE  = 1'b1;
  localparam logic IDLE_IDEX_BUBBLE = 1'b0;
  localparam logic IDLE_IFID_FLUSH  = 1'b0;
  localparam logic IDLE_PIPE_FREEZE = 1'b0;

endpackage

// File: rtl/hazard_match.sv
// Source-operand match: does a destination register feed a source the ID instruction reads.
// Latency: purely combinational.
// Backpressure: none; r0 and unused sources never match.
module hazard_match #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] dst,
  input  logic [REG_ADDR_W-1:0] addr_rs,
  input  logic [REG_ADDR_W-1:0] addr_rt,
  input  logic                  uses_rs,
  input  logic                  uses_rt,
  output logic                  hit
);

  // Writes to r0 are discarded, so they can never create a dependency.
  always_comb begin
    hit = (dst != '0) &&
          ((uses_rs && (dst == addr_rs)) || (uses_rt && (dst == addr_rt)));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard detection / stall controller beside IF/ID and ID/EX (load-use, memory wait, branch flush).
// Latency: control outputs combinational in the detection cycle; state and Stall_Cycles registered.
// Backpressure: DMem wait freezes the back end and holds all state; BRANCH_HAZARD_EN adds branch-operand stalls.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W      = 5,
  parameter int LOAD_USE_CYCLES = DEFAULT_LOAD_USE_CYCLES,
  parameter int CNT_W           = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  EXE_MemRead,
  input  logic                  EXE_RegWrite,
  input  logic [REG_ADDR_W-1:0] EXE_WriteRegDst,
  input  logic                  MEM_MemRead,
  input  logic                  MEM_MemAccess,
  input  logic [REG_ADDR_W-1:0] MEM_WriteRegDst,
  input  logic [REG_ADDR_W-1:0] ID_AddressRs,
  input  logic [REG_ADDR_W-1:0] ID_AddressRt,
  input  logic                  ID_UsesRs,
  input  logic                  ID_UsesRt,
  input  logic                  ID_Branch,
  input  logic                  Branch_Taken,
  input  logic                  DMem_Ready,
  output logic                  PC_Write,
  output logic                  IFID_Write,
  output logic                  IDEX_Bubble,
  output logic                  IFID_Flush,
  output logic                  Pipe_Freeze,
  output logic [CNT_W-1:0]      Stall_Cycles
);

  localparam int LW_W = $clog2(LOAD_USE_CYCLES + 1);

  state_t          state_q, state_d;
  logic [LW_W-1:0] lw_cnt_q, lw_cnt_d;
  logic            exe_hit, mem_hit;
  logic            load_use, mem_wait;

  hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_exe_match (
    .dst     (EXE_WriteRegDst),
    .addr_rs (ID_AddressRs),
    .addr_rt (ID_AddressRt),
    .uses_rs (ID_UsesRs),
    .uses_rt (ID_UsesRt),
    .hit     (exe_hit)
  );

  hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_mem_match (
    .dst     (MEM_WriteRegDst),
    .addr_rs (ID_AddressRs),
    .addr_rt (ID_AddressRt),
    .uses_rs (ID_UsesRs),
    .uses_rt (ID_UsesRt),
    .hit     (mem_hit)
  );

  assign load_use = EXE_MemRead && exe_hit;
  assign mem_wait = MEM_MemAccess && !DMem_Ready;

`ifdef BRANCH_HAZARD_EN
  logic branch_hazard;
  // A branch resolved in ID needs its operands now; any in-flight producer stalls it.
  assign branch_hazard = ID_Branch && ((EXE_RegWrite && exe_hit) || (MEM_MemRead && mem_hit));
`else
  logic unused_branch_inputs;
  assign unused_branch_inputs = ^{ID_Branch, EXE_RegWrite, MEM_MemRead, mem_hit};
`endif

  // Prioritised control decode: memory wait, then load-use, then branch hazard, then flush.
  always_comb begin
    state_d     = state_q;
    lw_cnt_d    = lw_cnt_q;
    PC_Write    = IDLE_PC_WRITE;
    IFID_Write  = IDLE_IFID_WRITE;
    IDEX_Bubble = IDLE_IDEX_BUBBLE;
    IFID_Flush  = IDLE_IFID_FLUSH;
    Pipe_Freeze = IDLE_PIPE_FREEZE;
    if (Reset) begin
      // idle outputs; state cleared in the register process
    end else if (mem_wait) begin
      // Whole pipe holds; EX is held too, so a pending hazard is re-seen afterwards.
      Pipe_Freeze = 1'b1;
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
    end else if (state_q == LOAD_WAIT) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
      lw_cnt_d    = lw_cnt_q - LW_W'(1);
      if (lw_cnt_q == LW_W'(1)) state_d = RUN;
    end else if (load_use) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
      if (LOAD_USE_CYCLES > 1) begin
        state_d  = LOAD_WAIT;
        lw_cnt_d = LW_W'(LOAD_USE_CYCLES - 1);
      end
`ifdef BRANCH_HAZARD_EN
    end else if (branch_hazard) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
`endif
    end else if (Branch_Taken) begin
      // Only flush when the branch actually leaves ID this cycle.
      IFID_Flush = 1'b1;
    end
  end

  // FSM state and remaining-bubble counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= RUN;
      lw_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      lw_cnt_q <= lw_cnt_d;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Stall_Cycles <= '0;
    end else if (!PC_Write && (Stall_Cycles != '1)) begin
      Stall_Cycles <= Stall_Cycles + CNT_W'(1);
    end
  end

endmodule
